// File: rtl/mem_buf_pkg.sv
// Shared types and constants for the PE memory buffer write path.
// Contents:
//   N_PE, ADDR_RAM, WID_RAM, BANK_W  geometry of the banked buffer
//   fill_state_e + IDLE/FILL/DRAIN   fill sequencer state encoding
//   bank_idx_t, ram_addr_t           bank index / bank address
//   ram_len_t, bank_cnt_t            word count per bank / bank count (one bit wider)
//   clamp_banks()                    limit a requested bank count to N_PE
//   bank_onehot()                    bank index to one-hot write enable
package mem_buf_pkg;

    localparam int unsigned N_PE     = 16;
    localparam int unsigned ADDR_RAM = 10;
    localparam int unsigned WID_RAM  = 16;
    localparam int unsigned BANK_W   = $clog2(N_PE);

    typedef logic [BANK_W-1:0]   bank_idx_t;
    typedef logic [ADDR_RAM-1:0] ram_addr_t;
    typedef logic [ADDR_RAM:0]   ram_len_t;
    typedef logic [BANK_W:0]     bank_cnt_t;

    typedef logic [1:0] fill_state_e;
    localparam fill_state_e IDLE  = 2'd0;
    localparam fill_state_e FILL  = 2'd1;
    localparam fill_state_e DRAIN = 2'd2;

    function automatic bank_cnt_t clamp_banks(input bank_cnt_t n);
        return (n > bank_cnt_t'(N_PE)) ? bank_cnt_t'(N_PE) : n;
    endfunction

    function automatic logic [N_PE-1:0] bank_onehot(input bank_idx_t b);
        logic [N_PE-1:0] r;
        r    = '0;
        r[b] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/buffer_fill_ctrl_if.sv
// Stream input and buffer mode-0 write port of the fill sequencer.
// Signals:
//   s_valid, s_data   upstream word stream (driven by the load path)
//   s_ready           sequencer can accept a word
//   m0_w_en           one-hot bank write enable, all-zero = no write
//   m0_w_addr         bank write address
//   m0_w_data         bank write data
// Modports:
//   slave   the fill sequencer (consumes the stream, drives the write port)
//   master  the environment (drives the stream, observes the write port)
interface buffer_fill_ctrl_if;
    import mem_buf_pkg::*;

    logic                 s_valid;
    logic                 s_ready;
    logic [WID_RAM-1:0]   s_data;
    logic [N_PE-1:0]      m0_w_en;
    ram_addr_t            m0_w_addr;
    logic [WID_RAM-1:0]   m0_w_data;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output m0_w_en,
        output m0_w_addr,
        output m0_w_data
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  m0_w_en,
        input  m0_w_addr,
        input  m0_w_data
    );

endinterface

// File: rtl/fill_addr_gen.sv
// Bank/offset counter pair for the bank-major buffer fill.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       latch base/len/n_banks and restart at bank 0, offset 0
//   step       advance one word (offset, then bank on wrap)
//   base       first address in every bank
//   len        words per bank
//   n_banks    banks to fill (clamped to N_PE on load)
//   bank       current bank index
//   addr       current write address, base+offset modulo 2^ADDR_RAM
//   last       current position is the final word of the fill
module fill_addr_gen
    import mem_buf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      step,
    input  ram_addr_t base,
    input  ram_len_t  len,
    input  bank_cnt_t n_banks,
    output bank_idx_t bank,
    output ram_addr_t addr,
    output logic      last
);

    ram_addr_t base_q;
    ram_len_t  len_q;
    bank_cnt_t nb_q;
    bank_idx_t bank_q;
    ram_addr_t offset_q;

    logic bank_end;
    logic last_bank;

    // len and n_banks are only loaded when nonzero, so the "-1" never underflows in use.
    assign bank_end  = ({1'b0, offset_q} == (len_q - ram_len_t'(1)));
    assign last_bank = ({1'b0, bank_q} == (nb_q - bank_cnt_t'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            len_q    <= '0;
            nb_q     <= '0;
            bank_q   <= '0;
            offset_q <= '0;
        end else if (load) begin
            base_q   <= base;
            len_q    <= len;
            nb_q     <= clamp_banks(n_banks);
            bank_q   <= '0;
            offset_q <= '0;
        end else if (step) begin
            if (bank_end) begin
                offset_q <= '0;
                bank_q   <= bank_q + bank_idx_t'(1);
            end else begin
                offset_q <= offset_q + ram_addr_t'(1);
            end
        end
    end

    assign bank = bank_q;
    assign addr = base_q + offset_q;
    assign last = bank_end && last_bank;

endmodule

// File: rtl/buffer_fill_ctrl.sv
// Write sequencer upstream of the PE memory buffer. Accepts a valid/ready word stream
// and writes it bank-major into the buffer's mode-0 port: bank 0 at base..base+len-1,
// then bank 1, and so on for n_banks banks.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           1-cycle pulse, latches cfg_*; ignored unless idle
//   cfg_base_addr   first address written in every bank
//   cfg_len         words per bank, 0..2^ADDR_RAM
//   cfg_n_banks     banks to fill from bank 0 (values above N_PE are clamped)
//   bus             stream input and buffer write port (slave side)
//   busy            high from the cycle after start until done
//   done            1-cycle pulse when the fill completes
module buffer_fill_ctrl
    import mem_buf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  ram_addr_t             cfg_base_addr,
    input  ram_len_t              cfg_len,
    input  bank_cnt_t             cfg_n_banks,
    buffer_fill_ctrl_if.slave     bus,
    output logic                  busy,
    output logic                  done
);

    fill_state_e state_q, state_d;
    logic        done_q, done_d;

    logic [N_PE-1:0]    w_en_q;
    ram_addr_t          w_addr_q;
    logic [WID_RAM-1:0] w_data_q;

    logic      accept;
    logic      cfg_empty;
    logic      load;
    bank_idx_t gen_bank;
    ram_addr_t gen_addr;
    logic      gen_last;

    assign accept    = (state_q == FILL) && bus.s_valid;
    assign cfg_empty = (cfg_len == '0) || (cfg_n_banks == '0);
    assign load      = start && (state_q == IDLE) && !cfg_empty;

    fill_addr_gen u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (accept),
        .base    (cfg_base_addr),
        .len     (cfg_len),
        .n_banks (cfg_n_banks),
        .bank    (gen_bank),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // An empty fill completes immediately without entering FILL.
                    if (cfg_empty) done_d  = 1'b1;
                    else           state_d = FILL;
                end
            end
            FILL: begin
                if (accept && gen_last) state_d = DRAIN;
            end
            DRAIN: begin
                // Final word is on the write port this cycle.
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            w_en_q   <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            w_en_q  <= accept ? bank_onehot(gen_bank) : '0;
            if (accept) begin
                w_addr_q <= gen_addr;
                w_data_q <= bus.s_data;
            end
        end
    end

    assign bus.s_ready   = (state_q == FILL);
    assign bus.m0_w_en   = w_en_q;
    assign bus.m0_w_addr = w_addr_q;
    assign bus.m0_w_data = w_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule
